// File: rtl/led_fade_if.sv
// Button inputs and brightness outputs of the LED fade controller; slave = controller side.
// LED_FADE_BREATHE_EN adds the breathing-mode button and status signals.
interface led_fade_if;
  logic       btnUp;
  logic       btnDown;
  logic [7:0] level;
  logic [7:0] target;
  logic       busy;
  logic       tick;
`ifdef LED_FADE_BREATHE_EN
  logic       btnMode;
  logic       breathing;
`endif

  modport master (
    output btnUp, btnDown,
`ifdef LED_FADE_BREATHE_EN
    output btnMode,
    input  breathing,
`endif
    input  level, target, busy, tick
  );

  modport slave (
    input  btnUp, btnDown,
`ifdef LED_FADE_BREATHE_EN
    input  btnMode,
    output breathing,
`endif
    output level, target, busy, tick
  );
endinterface

// File: rtl/led_fade_controller.sv
// Button-driven saturating target brightness; level ramps one LSB per prescaler tick toward it.
// LED_FADE_BREATHE_EN adds a breathing mode that bounces the target between 0 and MAX_LEVEL.
module led_fade_controller #(
  parameter int STEP      = 16,
  parameter int MAX_LEVEL = 255,
  parameter int TICK_DIV  = 97656
) (
  input  logic       clk,
  input  logic       resetn,
  led_fade_if.slave  bus
);

  localparam int         CW    = $clog2(TICK_DIV);
  localparam logic [7:0] MAXL  = 8'(MAX_LEVEL);
  localparam logic [7:0] STEP8 = 8'(STEP);
  localparam logic [8:0] STEP9 = 9'(STEP);

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    level_q, level_d;
  logic [7:0]    target_q, target_d;
  logic          busy_q, busy_d;
  logic          up_prev_q, down_prev_q;
  logic          up_edge, down_edge, tick;
  logic [8:0]    up_sum;
`ifdef LED_FADE_BREATHE_EN
  logic          mode_prev_q, breathing_q, breathing_d, mode_edge;

  assign mode_edge     = bus.btnMode & ~mode_prev_q;
  assign breathing_d   = breathing_q ^ mode_edge;
  assign bus.breathing = breathing_q;
`endif

  assign up_edge   = bus.btnUp & ~up_prev_q;
  assign down_edge = bus.btnDown & ~down_prev_q;
  assign tick      = (cnt_q == CW'(TICK_DIV - 1));
  assign cnt_d     = tick ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      level_q     <= '0;
      target_q    <= '0;
      busy_q      <= 1'b0;
      up_prev_q   <= 1'b0;
      down_prev_q <= 1'b0;
`ifdef LED_FADE_BREATHE_EN
      mode_prev_q <= 1'b0;
      breathing_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      target_q    <= target_d;
      busy_q      <= busy_d;
      up_prev_q   <= bus.btnUp;
      down_prev_q <= bus.btnDown;
`ifdef LED_FADE_BREATHE_EN
      mode_prev_q <= bus.btnMode;
      breathing_q <= breathing_d;
`endif
    end
  end

  // Leaving a ramp whenever the target has crossed level lets IDLE pick the new direction.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (target_q > level_q)      state_d = RAMP_UP;
        else if (target_q < level_q) state_d = RAMP_DOWN;
      end
      RAMP_UP: begin
        if (target_q <= level_q) state_d = IDLE;
        else if (tick && ({1'b0, level_q} + 9'd1 == {1'b0, target_q})) state_d = IDLE;
      end
      RAMP_DOWN: begin
        if (target_q >= level_q) state_d = IDLE;
        else if (tick && (level_q - 8'd1 == target_q)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (tick && state_q == RAMP_UP && target_q > level_q)
      level_d = level_q + 8'd1;
    else if (tick && state_q == RAMP_DOWN && target_q < level_q)
      level_d = level_q - 8'd1;
  end

  always_comb begin
    up_sum   = {1'b0, target_q} + STEP9;
    target_d = target_q;
`ifdef LED_FADE_BREATHE_EN
    if (mode_edge && !breathing_q) begin
      target_d = (level_q == MAXL) ? 8'd0 : MAXL;
    end else if (mode_edge) begin
      // Pin target to the level being delivered this edge so the fade freezes exactly.
      target_d = level_d;
    end else if (breathing_q) begin
      if (level_q == 8'd0)       target_d = MAXL;
      else if (level_q == MAXL)  target_d = 8'd0;
    end else begin
`else
    begin
`endif
      if (up_edge && !down_edge)
        target_d = (up_sum > {1'b0, MAXL}) ? MAXL : up_sum[7:0];
      else if (down_edge && !up_edge)
        target_d = (target_q < STEP8) ? 8'd0 : target_q - STEP8;
    end
    busy_d = (level_d != target_d);
  end

  assign bus.level  = level_q;
  assign bus.target = target_q;
  assign bus.busy   = busy_q;
  assign bus.tick   = tick;

endmodule
